top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter PIXEL_SIZE, default 8, bits per unsigned pixel.
REQ-002 Parameter LINE_SIZE, default 8, pixels per line (power of two).
REQ-003 Parameter NUM_TEMPLATES, default 4, templates compared in parallel.
REQ-004 Parameter NUM_OF_LINES, default 8, lines per accumulation window (power of two); ACC_W = $clog2(NUM_OF_LINES)+$clog2(LINE_SIZE)+2*PIXEL_SIZE.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high; clears all state.
REQ-007 I_in_line  input  unpacked [LINE_SIZE] x PIXEL_SIZE  image line, unsigned.
REQ-008 T_in_line  input  unpacked [LINE_SIZE][NUM_TEMPLATES] x PIXEL_SIZE  template pixels, index [pixel][template], unsigned.
REQ-009 Acc_lines_sum_I_square  output  ACC_W  accumulated sum of I^2.
REQ-010 Acc_lines_sum_I  output  ACC_W  accumulated sum of I.
REQ-011 Acc_lines_sum_T_x_I_out_top  output  unpacked [NUM_TEMPLATES] x ACC_W  accumulated sum of T[k]*I per template.

Function
REQ-012 Stage 1 (line stage) SHALL register, per edge, line sums over j=0..LINE_SIZE-1: S_I=sum I[j], S_I2=sum I[j]^2, S_TI[k]=sum T[j][k]*I[j].
REQ-013 Line-sum registers SHALL be $clog2(LINE_SIZE)+2*PIXEL_SIZE bits wide; all products and sums unsigned, zero-extended, never truncated.
REQ-014 Stage 2 (accumulator) SHALL, each edge with reset=0, add the stage-1 registers into the matching ACC_W accumulators.
REQ-015 Outputs SHALL be driven directly from the accumulator registers (no combinational path from inputs).
REQ-016 Latency: inputs sampled at edge n SHALL first appear in outputs after edge n+1.
REQ-017 Accumulation SHALL run every cycle; there is no valid/enable handshake.
REQ-018 More than NUM_OF_LINES accumulated lines SHALL wrap modulo 2^ACC_W, no saturation or flag.
REQ-019 Templates SHALL be computed fully in parallel; template k depends only on T[*][k] and I.

Reset
REQ-020 reset=1 at an edge SHALL clear stage-1 and stage-2 registers to 0; all outputs read 0 after that edge.
REQ-021 Reset has priority over accumulation; reset mid-window discards the partial window and the line sampled at the same edge.
REQ-022 First edge after reset deassertion SHALL add zeros (stage 1 was cleared), so outputs stay 0 one further cycle.

Structure
REQ-023 PIXEL_SIZE, LINE_SIZE, NUM_TEMPLATES, NUM_OF_LINES and derived widths (LINE_SUM_W, ACC_W) SHALL live in shared package top_pkg.
REQ-024 Stage 1 SHALL be a sub-module line_processor (one line in, S_I, S_I2, S_TI[] registered out); top instantiates it once plus the accumulators.

Verification (defaults)
REQ-025 reset for 1 cycle, then I=1, T=2 all pixels for 8 cycles -> after 9th post-reset edge: sum_I=64, sum_I2=64, each T_x_I=128.
REQ-026 I=255, T=255 for 8 cycles -> sum_I=16320, sum_I2=4161600, T_x_I=4161600 (no overflow in 22 bits).
REQ-027 Template isolation: I=3, T[*][0]=1, T[*][1]=0, T[*][2]=2, T[*][3]=255, one line then zeros -> T_x_I = {24, 0, 48, 6120}, sum_I=24, sum_I2=72.
REQ-028 Reset asserted mid-window after 3 lines of I=1 -> outputs 0 next edge; accumulation restarts from 0, prior lines lost.
REQ-029 Wrap: 17+ lines of I=255,T=255 -> sum_I2 equals exact total mod 2^22.
REQ-030 Random I/T for 100 cycles with reset pulse every 5 cycles -> outputs match reference model including 2-cycle latency and REQ-022.

Source files
------------

// File: rtl/top_pkg.sv
// Shared sizing for the line-correlation datapath: default geometry and the
// width rules used for line sums and window accumulators.
package top_pkg;

    localparam int PIXEL_SIZE    = 8;
    localparam int LINE_SIZE     = 8;
    localparam int NUM_TEMPLATES = 4;
    localparam int NUM_OF_LINES  = 8;

    // Sum of LINE_SIZE products of two PIXEL_SIZE values, never truncated.
    function automatic int calc_line_sum_w(input int line_size, input int pixel_size);
        return $clog2(line_size) + 2 * pixel_size;
    endfunction

    function automatic int calc_acc_w(input int num_lines, input int line_size,
                                      input int pixel_size);
        return $clog2(num_lines) + calc_line_sum_w(line_size, pixel_size);
    endfunction

    localparam int LINE_SUM_W = calc_line_sum_w(LINE_SIZE, PIXEL_SIZE);
    localparam int ACC_W      = calc_acc_w(NUM_OF_LINES, LINE_SIZE, PIXEL_SIZE);

endpackage

// File: rtl/top_line_processor.sv
// Line stage: reduces one image line to registered sum(I), sum(I^2) and
// sum(T[k]*I) for every template in parallel.
module line_processor #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 8,
    parameter int NUM_TEMPLATES = 4,
    parameter int LINE_SUM_W    = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_SIZE-1:0] i_line [LINE_SIZE],
    input  logic [PIXEL_SIZE-1:0] t_line [LINE_SIZE][NUM_TEMPLATES],
    output logic [LINE_SUM_W-1:0] s_i,
    output logic [LINE_SUM_W-1:0] s_i2,
    output logic [LINE_SUM_W-1:0] s_ti [NUM_TEMPLATES]
);

    logic [LINE_SUM_W-1:0] sum_i_c;
    logic [LINE_SUM_W-1:0] sum_i2_c;
    logic [LINE_SUM_W-1:0] sum_ti_c [NUM_TEMPLATES];

    // Operands are widened to the full line-sum width before multiplying so
    // neither the product nor the running sum can lose carries.
    always_comb begin
        sum_i_c  = '0;
        sum_i2_c = '0;
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            sum_ti_c[k] = '0;
        end
        for (int j = 0; j < LINE_SIZE; j++) begin
            sum_i_c  = sum_i_c + LINE_SUM_W'(i_line[j]);
            sum_i2_c = sum_i2_c + LINE_SUM_W'(i_line[j]) * LINE_SUM_W'(i_line[j]);
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                sum_ti_c[k] = sum_ti_c[k]
                            + LINE_SUM_W'(t_line[j][k]) * LINE_SUM_W'(i_line[j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_i  <= '0;
            s_i2 <= '0;
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                s_ti[k] <= '0;
            end
        end else begin
            s_i  <= sum_i_c;
            s_i2 <= sum_i2_c;
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                s_ti[k] <= sum_ti_c[k];
            end
        end
    end

endmodule

// File: rtl/top.sv
// Template-correlation accumulator: line stage followed by free-running
// window accumulators that wrap modulo 2^ACC_W.
module top
    import top_pkg::calc_line_sum_w, top_pkg::calc_acc_w;
#(
    parameter int PIXEL_SIZE    = top_pkg::PIXEL_SIZE,
    parameter int LINE_SIZE     = top_pkg::LINE_SIZE,
    parameter int NUM_TEMPLATES = top_pkg::NUM_TEMPLATES,
    parameter int NUM_OF_LINES  = top_pkg::NUM_OF_LINES,
    localparam int LINE_SUM_W   = calc_line_sum_w(LINE_SIZE, PIXEL_SIZE),
    localparam int ACC_W        = calc_acc_w(NUM_OF_LINES, LINE_SIZE, PIXEL_SIZE)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [PIXEL_SIZE-1:0] I_in_line [LINE_SIZE],
    input  logic [PIXEL_SIZE-1:0] T_in_line [LINE_SIZE][NUM_TEMPLATES],
    output logic [ACC_W-1:0]      Acc_lines_sum_I_square,
    output logic [ACC_W-1:0]      Acc_lines_sum_I,
    output logic [ACC_W-1:0]      Acc_lines_sum_T_x_I_out_top [NUM_TEMPLATES]
);

    logic [LINE_SUM_W-1:0] line_s_i;
    logic [LINE_SUM_W-1:0] line_s_i2;
    logic [LINE_SUM_W-1:0] line_s_ti [NUM_TEMPLATES];

    line_processor #(
        .PIXEL_SIZE    (PIXEL_SIZE),
        .LINE_SIZE     (LINE_SIZE),
        .NUM_TEMPLATES (NUM_TEMPLATES),
        .LINE_SUM_W    (LINE_SUM_W)
    ) u_line_processor (
        .clk    (CLK),
        .reset  (reset),
        .i_line (I_in_line),
        .t_line (T_in_line),
        .s_i    (line_s_i),
        .s_i2   (line_s_i2),
        .s_ti   (line_s_ti)
    );

    // Outputs are the accumulator flops themselves; overflow wraps silently.
    always_ff @(posedge CLK) begin
        if (reset) begin
            Acc_lines_sum_I        <= '0;
            Acc_lines_sum_I_square <= '0;
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                Acc_lines_sum_T_x_I_out_top[k] <= '0;
            end
        end else begin
            Acc_lines_sum_I        <= Acc_lines_sum_I + ACC_W'(line_s_i);
            Acc_lines_sum_I_square <= Acc_lines_sum_I_square + ACC_W'(line_s_i2);
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                Acc_lines_sum_T_x_I_out_top[k] <= Acc_lines_sum_T_x_I_out_top[k]
                                                + ACC_W'(line_s_ti[k]);
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: every cycle the reference window totals are
// queued at drive time and compared by an independent monitor.
module tb_top;

    localparam int P     = 8;
    localparam int L     = 8;
    localparam int NT    = 4;
    localparam int ACC_W = 22;

    typedef struct packed {
        logic [ACC_W-1:0]         si;
        logic [ACC_W-1:0]         si2;
        logic [NT-1:0][ACC_W-1:0] ti;
    } sums_t;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [P-1:0]     I_in_line [L];
    logic [P-1:0]     T_in_line [L][NT];
    logic [ACC_W-1:0] Acc_lines_sum_I_square;
    logic [ACC_W-1:0] Acc_lines_sum_I;
    logic [ACC_W-1:0] Acc_lines_sum_T_x_I_out_top [NT];

    top dut (
        .CLK                         (CLK),
        .reset                       (reset),
        .I_in_line                   (I_in_line),
        .T_in_line                   (T_in_line),
        .Acc_lines_sum_I_square      (Acc_lines_sum_I_square),
        .Acc_lines_sum_I             (Acc_lines_sum_I),
        .Acc_lines_sum_T_x_I_out_top (Acc_lines_sum_T_x_I_out_top)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    sums_t sb_q [$];

    // Reference: outputs after an edge are the wrapped total of every line
    // sampled strictly after the last reset edge and before this edge.
    sums_t acc_m  = '0;
    sums_t pend_m = '0;

    logic [P-1:0] cur_i [L];
    logic [P-1:0] cur_t [L][NT];

    task automatic check_val(input string name, input logic [ACC_W-1:0] act,
                             input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_uniform(input int iv, input int tv);
        for (int j = 0; j < L; j++) begin
            cur_i[j] = P'(iv);
            for (int k = 0; k < NT; k++) cur_t[j][k] = P'(tv);
        end
    endtask

    task automatic step(input logic rst);
        longint si, si2;
        longint sti [NT];
        sums_t c;
        @(negedge CLK);
        reset = rst;
        si = 0;
        si2 = 0;
        for (int k = 0; k < NT; k++) sti[k] = 0;
        for (int j = 0; j < L; j++) begin
            I_in_line[j] = cur_i[j];
            si  += longint'(cur_i[j]);
            si2 += longint'(cur_i[j]) * longint'(cur_i[j]);
            for (int k = 0; k < NT; k++) begin
                T_in_line[j][k] = cur_t[j][k];
                sti[k] += longint'(cur_t[j][k]) * longint'(cur_i[j]);
            end
        end
        c.si  = ACC_W'(si);
        c.si2 = ACC_W'(si2);
        for (int k = 0; k < NT; k++) c.ti[k] = ACC_W'(sti[k]);
        if (rst) begin
            acc_m  = '0;
            pend_m = '0;
        end else begin
            acc_m.si  = acc_m.si + pend_m.si;
            acc_m.si2 = acc_m.si2 + pend_m.si2;
            for (int k = 0; k < NT; k++) acc_m.ti[k] = acc_m.ti[k] + pend_m.ti[k];
            pend_m = c;
        end
        sb_q.push_back(acc_m);
    endtask

    task automatic spot(input string name, input int esi, input int esi2,
                        input int et0, input int et1, input int et2, input int et3);
        @(posedge CLK);
        #2;
        check_val({name, "_sum_I"}, Acc_lines_sum_I, ACC_W'(esi));
        check_val({name, "_sum_I2"}, Acc_lines_sum_I_square, ACC_W'(esi2));
        check_val({name, "_TxI0"}, Acc_lines_sum_T_x_I_out_top[0], ACC_W'(et0));
        check_val({name, "_TxI1"}, Acc_lines_sum_T_x_I_out_top[1], ACC_W'(et1));
        check_val({name, "_TxI2"}, Acc_lines_sum_T_x_I_out_top[2], ACC_W'(et2));
        check_val({name, "_TxI3"}, Acc_lines_sum_T_x_I_out_top[3], ACC_W'(et3));
    endtask

    initial begin : monitor
        sums_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("sb_sum_I", Acc_lines_sum_I, e.si);
                check_val("sb_sum_I2", Acc_lines_sum_I_square, e.si2);
                for (int k = 0; k < NT; k++)
                    check_val($sformatf("sb_TxI%0d", k), Acc_lines_sum_T_x_I_out_top[k], e.ti[k]);
            end
        end
    end

    initial begin : stimulus
        set_uniform(0, 0);
        for (int j = 0; j < L; j++) begin
            I_in_line[j] = '0;
            for (int k = 0; k < NT; k++) T_in_line[j][k] = '0;
        end

        // Small uniform lines, full window.
        set_uniform(0, 0);
        step(1'b1);
        set_uniform(1, 2);
        repeat (8) step(1'b0);
        set_uniform(0, 0);
        step(1'b0);
        spot("ones", 64, 64, 128, 128, 128, 128);

        // Full-scale pixels, full window, no overflow.
        step(1'b1);
        set_uniform(255, 255);
        repeat (8) step(1'b0);
        set_uniform(0, 0);
        step(1'b0);
        spot("max", 16320, 4161600, 4161600, 4161600, 4161600, 4161600);

        // Template isolation: each template sees only its own column.
        step(1'b1);
        for (int j = 0; j < L; j++) begin
            cur_i[j]    = 8'd3;
            cur_t[j][0] = 8'd1;
            cur_t[j][1] = 8'd0;
            cur_t[j][2] = 8'd2;
            cur_t[j][3] = 8'd255;
        end
        step(1'b0);
        set_uniform(0, 0);
        step(1'b0);
        spot("isol", 24, 72, 24, 0, 48, 6120);

        // Reset mid-window discards accumulated lines and the line at the reset edge.
        step(1'b1);
        set_uniform(1, 0);
        repeat (3) step(1'b0);
        step(1'b1);
        spot("midrst", 0, 0, 0, 0, 0, 0);
        repeat (2) step(1'b0);
        set_uniform(0, 0);
        step(1'b0);
        spot("restart", 16, 16, 0, 0, 0, 0);

        // Wrap beyond the window: 20 full-scale lines.
        step(1'b1);
        set_uniform(255, 255);
        repeat (20) step(1'b0);
        set_uniform(0, 0);
        step(1'b0);
        spot("wrap", 40800, 2015392, 2015392, 2015392, 2015392, 2015392);

        // Random lines with a reset pulse every fifth cycle.
        for (int cyc = 0; cyc < 100; cyc++) begin
            for (int j = 0; j < L; j++) begin
                cur_i[j] = P'($urandom_range(0, 255));
                for (int k = 0; k < NT; k++) cur_t[j][k] = P'($urandom_range(0, 255));
            end
            step((cyc % 5) == 0);
        end
        set_uniform(0, 0);
        repeat (2) step(1'b0);

        repeat (3) @(posedge CLK);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain actual=%0d expected=0 entries left", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
